intersection_sched: RTL and testbench

INTERSECTION_SCHED -- requirements
Module: intersection_sched

---
 rtl/intersection_sched.sv | 106 ++++++++++
 tb/tb_intersection_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_sched.sv
// intersection_sched: two-road traffic light scheduler with demand-driven greens
// and an all-red pedestrian walk phase; all timing counted in divided ticks.
module intersection_sched #(
    parameter int TICK_DIV = 100_000_000,
    parameter int GMIN     = 5,
    parameter int GMAX     = 20,
    parameter int YEL      = 3,
    parameter int ARED     = 1,
    parameter int WALK     = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sa,
    input  logic       sb,
    input  logic       ped_req,
    output logic [2:0] la,
    output logic [2:0] lb,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        AG  = 3'd0,
        AY  = 3'd1,
        AR1 = 3'd2,
        BG  = 3'd3,
        BY  = 3'd4,
        AR2 = 3'd5,
        PW  = 3'd6,
        ILL = 3'd7
    } state_t;

    localparam int             DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0]  DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [7:0]     G_MIN    = 8'(GMIN);
    localparam logic [7:0]     G_MAX    = 8'(GMAX);
    localparam logic [7:0]     Y_LEN    = 8'(YEL);
    localparam logic [7:0]     R_LEN    = 8'(ARED);
    localparam logic [7:0]     W_LEN    = 8'(WALK);

    state_t        state, state_n;
    logic [DW-1:0] div;
    logic [7:0]    timer, e;
    logic          tick;
    logic          ped_prev, ped_pend, ped_edge, grant;
    logic          next_road, next_road_n;

    assign tick     = (div == DIV_LAST);
    assign ped_edge = ped_req & ~ped_prev;
    assign grant    = (state_n == PW) && (state != PW);

    always_comb begin
        e           = (timer == 8'hFF) ? 8'hFF : timer + 8'd1;
        state_n     = state;
        next_road_n = next_road;
        if (state == ILL) begin
            state_n = AR2;
        end else if (tick) begin
            case (state)
                AG:  if ((sb | ped_pend) && (e >= G_MAX || (e >= G_MIN && !sa))) state_n = AY;
                AY:  if (e == Y_LEN) state_n = AR1;
                BG:  if ((sa | ped_pend) && (e >= G_MAX || (e >= G_MIN && !sb))) state_n = BY;
                BY:  if (e == Y_LEN) state_n = AR2;
                AR1: if (e == R_LEN) begin
                    state_n     = ped_pend ? PW : BG;
                    next_road_n = ped_pend ? 1'b1 : next_road;
                end
                AR2: if (e == R_LEN) begin
                    state_n     = ped_pend ? PW : AG;
                    next_road_n = ped_pend ? 1'b0 : next_road;
                end
                PW:  if (e == W_LEN) state_n = next_road ? BG : AG;
                default: state_n = state;
            endcase
        end
    end

    // Lamps and debug outputs depend on the state register alone.
    always_comb begin
        la    = (state == AG) ? 3'b110 : (state == AY) ? 3'b100 : 3'b111;
        lb    = (state == BG) ? 3'b110 : (state == BY) ? 3'b100 : 3'b111;
        walk  = (state == PW);
        phase = state;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= AG;
            div       <= '0;
            timer     <= 8'd0;
            ped_prev  <= 1'b0;
            ped_pend  <= 1'b0;
            ped_ack   <= 1'b0;
            next_road <= 1'b0;
        end else begin
            div       <= tick ? '0 : div + DW'(1);
            state     <= state_n;
            next_road <= next_road_n;
            timer     <= (state_n != state) ? 8'd0 : (tick ? e : timer);
            ped_prev  <= ped_req;
            // A fresh request in the grant cycle survives the clear.
            ped_pend  <= ped_edge | (ped_pend & ~grant);
            ped_ack   <= grant;
        end
    end
endmodule

// File: tb/tb_intersection_sched.sv
// tb_intersection_sched: scoreboard bench; each queued entry is the expected
// state for one whole tick window (TICK_DIV cycles) plus pedestrian stimulus.
module tb_intersection_sched;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sa = 1'b0, sb = 1'b0, ped_req = 1'b0;
    logic [2:0] la, lb, phase;
    logic       walk, ped_ack;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] ph;
        bit         ack;
        int         ped_at;
    } exp_t;

    exp_t q[$];
    exp_t x;

    intersection_sched #(
        .TICK_DIV(TD), .GMIN(2), .GMAX(4), .YEL(2), .ARED(1), .WALK(3)
    ) dut (
        .clk(clk), .reset(reset), .sa(sa), .sb(sb), .ped_req(ped_req),
        .la(la), .lb(lb), .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] la_of(input logic [2:0] ph);
        return (ph == 3'd0) ? 3'b110 : (ph == 3'd1) ? 3'b100 : 3'b111;
    endfunction

    function automatic logic [2:0] lb_of(input logic [2:0] ph);
        return (ph == 3'd3) ? 3'b110 : (ph == 3'd4) ? 3'b100 : 3'b111;
    endfunction

    task automatic push(input logic [2:0] ph, input int n, input bit ack, input int ped_at);
        exp_t t;
        for (int i = 0; i < n; i++) begin
            t.ph     = ph;
            t.ack    = ack && (i == 0);
            t.ped_at = (i == 0) ? ped_at : -1;
            q.push_back(t);
        end
    endtask

    task automatic apply_reset();
        ped_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        sa = 1'b1;
        sb = 1'b1;
        ped_req = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({la, lb, walk, ped_ack, phase} !== {3'b110, 3'b111, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset: got la=%b lb=%b walk=%b ack=%b ph=%0d, want la=110 lb=111 walk=0 ack=0 ph=0",
                     la, lb, walk, ped_ack, phase);
        end
    endtask

    task automatic test_idle();
        sa = 1'b0; sb = 1'b0;
        apply_reset();
        push(3'd0, 40, 1'b0, -1);
        while (q.size() > 0) begin
            x = q.pop_front();
            for (int c = 0; c < TD; c++) begin
                ped_req = (c == x.ped_at);
                n_chk++;
                if ({phase, la, lb, walk, ped_ack} !== {x.ph, la_of(x.ph), lb_of(x.ph), x.ph == 3'd6, x.ack && (c == 0)}) begin
                    n_fail++;
                    $display("FAIL idle t=%0t: got ph=%0d la=%b lb=%b walk=%b ack=%b, want ph=%0d ack=%b",
                             $time, phase, la, lb, walk, ped_ack, x.ph, x.ack && (c == 0));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_demand();
        sa = 1'b0; sb = 1'b1;
        apply_reset();
        push(3'd0, 2, 1'b0, -1);
        push(3'd1, 2, 1'b0, -1);
        push(3'd2, 1, 1'b0, -1);
        push(3'd3, 3, 1'b0, -1);
        while (q.size() > 0) begin
            x = q.pop_front();
            for (int c = 0; c < TD; c++) begin
                ped_req = (c == x.ped_at);
                n_chk++;
                if ({phase, la, lb, walk, ped_ack} !== {x.ph, la_of(x.ph), lb_of(x.ph), x.ph == 3'd6, x.ack && (c == 0)}) begin
                    n_fail++;
                    $display("FAIL demand t=%0t: got ph=%0d la=%b lb=%b walk=%b ack=%b, want ph=%0d ack=%b",
                             $time, phase, la, lb, walk, ped_ack, x.ph, x.ack && (c == 0));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_max_green();
        sa = 1'b1; sb = 1'b1;
        apply_reset();
        push(3'd0, 4, 1'b0, -1);
        push(3'd1, 2, 1'b0, -1);
        push(3'd2, 1, 1'b0, -1);
        push(3'd3, 4, 1'b0, -1);
        push(3'd4, 2, 1'b0, -1);
        push(3'd5, 1, 1'b0, -1);
        push(3'd0, 2, 1'b0, -1);
        while (q.size() > 0) begin
            x = q.pop_front();
            for (int c = 0; c < TD; c++) begin
                ped_req = (c == x.ped_at);
                n_chk++;
                if ({phase, la, lb, walk, ped_ack} !== {x.ph, la_of(x.ph), lb_of(x.ph), x.ph == 3'd6, x.ack && (c == 0)}) begin
                    n_fail++;
                    $display("FAIL max_green t=%0t: got ph=%0d la=%b lb=%b walk=%b ack=%b, want ph=%0d ack=%b",
                             $time, phase, la, lb, walk, ped_ack, x.ph, x.ack && (c == 0));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_pedestrian();
        sa = 1'b0; sb = 1'b0;
        apply_reset();
        push(3'd0, 2, 1'b0, 0);
        push(3'd1, 2, 1'b0, -1);
        push(3'd2, 1, 1'b0, -1);
        push(3'd6, 3, 1'b1, -1);
        push(3'd3, 3, 1'b0, -1);
        while (q.size() > 0) begin
            x = q.pop_front();
            for (int c = 0; c < TD; c++) begin
                ped_req = (c == x.ped_at);
                n_chk++;
                if ({phase, la, lb, walk, ped_ack} !== {x.ph, la_of(x.ph), lb_of(x.ph), x.ph == 3'd6, x.ack && (c == 0)}) begin
                    n_fail++;
                    $display("FAIL pedestrian t=%0t: got ph=%0d la=%b lb=%b walk=%b ack=%b, want ph=%0d ack=%b",
                             $time, phase, la, lb, walk, ped_ack, x.ph, x.ack && (c == 0));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        sa = 1'b0; sb = 1'b0;
        apply_reset();
        push(3'd0, 2, 1'b0, 0);
        push(3'd1, 2, 1'b0, -1);
        push(3'd2, 1, 1'b0, TD - 1);
        push(3'd6, 3, 1'b1, -1);
        push(3'd3, 2, 1'b0, -1);
        push(3'd4, 2, 1'b0, -1);
        push(3'd5, 1, 1'b0, -1);
        push(3'd6, 3, 1'b1, -1);
        push(3'd0, 3, 1'b0, -1);
        while (q.size() > 0) begin
            x = q.pop_front();
            for (int c = 0; c < TD; c++) begin
                ped_req = (c == x.ped_at);
                n_chk++;
                if ({phase, la, lb, walk, ped_ack} !== {x.ph, la_of(x.ph), lb_of(x.ph), x.ph == 3'd6, x.ack && (c == 0)}) begin
                    n_fail++;
                    $display("FAIL back_to_back t=%0t: got ph=%0d la=%b lb=%b walk=%b ack=%b, want ph=%0d ack=%b",
                             $time, phase, la, lb, walk, ped_ack, x.ph, x.ack && (c == 0));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid_walk();
        sa = 1'b0; sb = 1'b0;
        apply_reset();
        push(3'd0, 2, 1'b0, 0);
        push(3'd1, 2, 1'b0, -1);
        push(3'd2, 1, 1'b0, -1);
        push(3'd6, 1, 1'b1, -1);
        while (q.size() > 0) begin
            x = q.pop_front();
            for (int c = 0; c < TD; c++) begin
                ped_req = (c == x.ped_at);
                n_chk++;
                if ({phase, la, lb, walk, ped_ack} !== {x.ph, la_of(x.ph), lb_of(x.ph), x.ph == 3'd6, x.ack && (c == 0)}) begin
                    n_fail++;
                    $display("FAIL walk_pre t=%0t: got ph=%0d la=%b lb=%b walk=%b ack=%b, want ph=%0d ack=%b",
                             $time, phase, la, lb, walk, ped_ack, x.ph, x.ack && (c == 0));
                end
                @(negedge clk);
            end
        end
        n_chk++;
        if ({walk, phase} !== {1'b1, 3'd6}) begin
            n_fail++;
            $display("FAIL walk_active: got walk=%b ph=%0d, want walk=1 ph=6", walk, phase);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({la, lb, walk, ped_ack, phase} !== {3'b110, 3'b111, 1'b0, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL async_reset: got la=%b lb=%b walk=%b ack=%b ph=%0d, want la=110 lb=111 walk=0 ack=0 ph=0",
                     la, lb, walk, ped_ack, phase);
        end
        sb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push(3'd0, 2, 1'b0, -1);
        push(3'd1, 2, 1'b0, -1);
        while (q.size() > 0) begin
            x = q.pop_front();
            for (int c = 0; c < TD; c++) begin
                ped_req = (c == x.ped_at);
                n_chk++;
                if ({phase, la, lb, walk, ped_ack} !== {x.ph, la_of(x.ph), lb_of(x.ph), x.ph == 3'd6, x.ack && (c == 0)}) begin
                    n_fail++;
                    $display("FAIL walk_post t=%0t: got ph=%0d la=%b lb=%b walk=%b ack=%b, want ph=%0d ack=%b",
                             $time, phase, la, lb, walk, ped_ack, x.ph, x.ack && (c == 0));
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at t=%0t, want earlier completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_demand();
        test_max_green();
        test_pedestrian();
        test_back_to_back();
        test_reset_mid_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
